seven_segment_reader: RTL and testbench
=======================================

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CNT, default 1, is the number of consecutive identical samples (1..15) required before a digit is captured.
REQ-002 Parameter DIGIT_MASK, default 4'b1111, selects the digit positions (bit n = BCDn) that must be captured to complete a frame.
REQ-003 Port clk  input  1  is the single clock; all logic is rising-edge.
REQ-004 Port rst  input  1  is the reset, which SHALL be synchronous and active-high.
REQ-005 Port DIGIT  input  4  is the active-low digit select of the multiplexed display bus.
REQ-006 Port DISPLAY  input  7  is the active-low segment pattern a..g, with bit 6 = a.
REQ-007 Ports BCD0, BCD1, BCD2, BCD3  output  4 each  hold the last complete frame; 4'hF = blank.
REQ-008 Port FRAME_VALID  output  1  is a one-cycle pulse when BCD0..BCD3 are updated.
REQ-009 Port ERR  output  1  is a one-cycle pulse on a protocol error.
REQ-010 Port ERR_COUNT  output  8  is the saturating error count (see Configuration).

Function
REQ-011 DIGIT and DISPLAY SHALL be registered into a sample stage every cycle; all decisions use the sampled values.
REQ-012 Legal select = exactly one DIGIT bit low; all-ones = idle (no action, no error); two or more bits low = error.
REQ-013 Decode: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 1111111=blank (4'hF); any other pattern = error.
REQ-014 Stability counter: increments while the sample equals the previous sample; on change it reloads to 1; a capture fires when the count reaches STABLE_CNT, and at most once per stable run.
REQ-015 A capture on a digit outside DIGIT_MASK SHALL be ignored (no state change, no error).
REQ-016 FSM states: SYNC and COLLECT; in SYNC, only a capture of the lowest-index masked digit is accepted, which stores its value, sets its seen bit, and moves to COLLECT.
REQ-017 In COLLECT, a capture of an unseen masked digit stores it into a shadow register and sets its seen bit.
REQ-018 In COLLECT, a capture of an already-seen digit discards the partial frame and is re-evaluated as in SYNC in the same cycle.
REQ-019 When the seen bits equal DIGIT_MASK, BCDn (masked n) SHALL load the shadow values, including the completing value, and FRAME_VALID pulses; the seen bits then clear and the FSM returns to SYNC.
REQ-020 Latency: an input presented before edge k (sampled at k) that completes a frame SHALL produce FRAME_VALID=1 and the new BCD values in the cycle after edge k+1.
REQ-021 On an error (illegal select, or an invalid pattern reaching STABLE_CNT), ERR pulses for 1 cycle, the partial frame is discarded, the FSM goes to SYNC, and the BCD outputs are unchanged.
REQ-022 BCD outputs for unmasked digits SHALL remain 4'hF permanently.

Reset
REQ-023 While rst=1 at a clock edge: BCD0..BCD3=4'hF, FRAME_VALID=0, ERR=0, ERR_COUNT=0, state=SYNC, seen=0, stability count=0, sample DIGIT=4'b1111, sample DISPLAY=7'b1111111.
REQ-024 A reset mid-frame SHALL discard the partial frame; no FRAME_VALID is issued for it.

Configuration
REQ-025 With macro SEVEN_SEGMENT_READER_ERRCNT_EN defined, ERR_COUNT increments on each ERR pulse and saturates at 8'd255.
REQ-026 Without SEVEN_SEGMENT_READER_ERRCNT_EN, ERR_COUNT SHALL be constant 8'd0 with no counter logic; ERR behaviour is identical in both builds.

Structure
REQ-027 Package seven_segment_pkg SHALL hold the segment constants SEG_0..SEG_9 and SEG_BLANK, BCD_BLANK=4'hF, and the FSM state typedef.
REQ-028 Sub-module seg_to_bcd (combinational: 7-bit pattern -> 4-bit value, valid, blank) SHALL perform the decode.

Verification
REQ-029 DIGIT_MASK=0011, STABLE_CNT=1; alternate 1110/0000110 and 1101/1001111 -> FRAME_VALID every 2nd cycle, BCD0=3, BCD1=1, BCD2=BCD3=F.
REQ-030 Digit0 with DISPLAY=1010101 -> ERR 1 cycle, BCD unchanged, next FRAME_VALID only after a fresh digit0 and digit1.
REQ-031 STABLE_CNT=3; digit0 shows 8 for 2 cycles then 9 for 3 cycles, then digit1..3 stable -> frame BCD0=9, never 8.
REQ-032 DIGIT=1100 -> ERR pulse, no capture; DIGIT=1111 -> no ERR, no capture.
REQ-033 Reset asserted after digit0 is captured, before digit1 -> no FRAME_VALID, all BCD=F, ERR_COUNT=0.
REQ-034 300 consecutive error events -> ERR_COUNT=255 with SEVEN_SEGMENT_READER_ERRCNT_EN, 0 without.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment bus reader: active-low segment codes,
// blank code and the frame-assembly state type.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        SYNC    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Index of the lowest set bit; a frame always starts on this digit.
    function automatic logic [1:0] lowest_index(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i[1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational decode of an active-low a..g segment pattern (bit 6 = a)
// into a digit value, with flags for a recognised pattern and for blank.
module seg_to_bcd
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank
);

    // Pattern lookup; anything not in the table is reported as invalid.
    always_comb begin
        value = BCD_BLANK;
        valid = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default: begin
                value = BCD_BLANK;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Snoops a multiplexed active-low seven-segment bus and rebuilds complete frames.
// Define SEVEN_SEGMENT_READER_ERRCNT_EN to enable the saturating ERR_COUNT.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 32'd1,
    parameter logic [3:0]  DIGIT_MASK = 4'b1111
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DIGIT,
    input  logic [6:0] DISPLAY,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [3:0] BCD2,
    output logic [3:0] BCD3,
    output logic       FRAME_VALID,
    output logic       ERR,
    output logic [7:0] ERR_COUNT
);

    localparam logic [4:0] STAB_W    = 5'(STABLE_CNT);
    localparam logic [1:0] FIRST_IDX = lowest_index(DIGIT_MASK);

    logic [3:0]       samp_digit_r;
    logic [6:0]       samp_disp_r;
    logic [4:0]       stab_cnt_r;
    logic             same_s;
    logic             capture_s;

    logic [1:0]       sel_idx_s;
    logic             sel_idle_s;
    logic             sel_bad_s;

    logic [3:0]       dec_val_s;
    logic             dec_valid_s;
    logic             dec_blank_s;
    logic [3:0]       cap_val_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       seen_r;
    logic [3:0]       seen_nxt_s;
    logic [3:0]       base_seen_s;
    logic             fresh_s;
    logic [3:0][3:0]  shadow_r;
    logic [3:0][3:0]  shadow_nxt_s;
    logic [3:0][3:0]  bcd_r;
    logic [3:0][3:0]  bcd_nxt_s;
    logic             fv_r;
    logic             fv_nxt_s;
    logic             err_r;
    logic             err_nxt_s;

    assign same_s    = (DIGIT == samp_digit_r) && (DISPLAY == samp_disp_r);
    assign capture_s = (stab_cnt_r == STAB_W);

    // Sample stage and run-length counter; the counter saturates above any
    // legal threshold so a held input captures only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_digit_r <= 4'b1111;
            samp_disp_r  <= 7'b1111111;
            stab_cnt_r   <= 5'd0;
        end else begin
            samp_digit_r <= DIGIT;
            samp_disp_r  <= DISPLAY;
            if (!same_s) begin
                stab_cnt_r <= 5'd1;
            end else if (stab_cnt_r != 5'd31) begin
                stab_cnt_r <= stab_cnt_r + 5'd1;
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // Classify the sampled digit select.
    always_comb begin
        sel_idx_s  = 2'd0;
        sel_idle_s = 1'b0;
        sel_bad_s  = 1'b0;
        case (samp_digit_r)
            4'b1110: sel_idx_s  = 2'd0;
            4'b1101: sel_idx_s  = 2'd1;
            4'b1011: sel_idx_s  = 2'd2;
            4'b0111: sel_idx_s  = 2'd3;
            4'b1111: sel_idle_s = 1'b1;
            default: sel_bad_s  = 1'b1;
        endcase
    end

    seg_to_bcd u_dec (
        .seg   (samp_disp_r),
        .value (dec_val_s),
        .valid (dec_valid_s),
        .blank (dec_blank_s)
    );

    assign cap_val_s = dec_blank_s ? BCD_BLANK : dec_val_s;

    // Frame assembly: next state, seen bits, shadow values and output pulses.
    always_comb begin
        state_nxt_s  = state_r;
        seen_nxt_s   = seen_r;
        shadow_nxt_s = shadow_r;
        bcd_nxt_s    = bcd_r;
        fv_nxt_s     = 1'b0;
        err_nxt_s    = 1'b0;
        base_seen_s  = seen_r;
        fresh_s      = (state_r == SYNC);
        if (!capture_s) begin
            state_nxt_s = state_r;
        end else if (sel_bad_s) begin
            err_nxt_s   = 1'b1;
            seen_nxt_s  = 4'b0000;
            state_nxt_s = SYNC;
        end else if (sel_idle_s || !DIGIT_MASK[sel_idx_s]) begin
            state_nxt_s = state_r;
        end else if (!dec_valid_s) begin
            err_nxt_s   = 1'b1;
            seen_nxt_s  = 4'b0000;
            state_nxt_s = SYNC;
        end else begin
            // A repeated digit means we missed the frame boundary: restart from it.
            if (state_r == COLLECT && seen_r[sel_idx_s]) begin
                base_seen_s = 4'b0000;
                fresh_s     = 1'b1;
            end else begin
                base_seen_s = seen_r;
            end
            if (fresh_s && (sel_idx_s != FIRST_IDX)) begin
                seen_nxt_s  = 4'b0000;
                state_nxt_s = SYNC;
            end else begin
                shadow_nxt_s[sel_idx_s] = cap_val_s;
                seen_nxt_s = base_seen_s | (4'b0001 << sel_idx_s);
                if (seen_nxt_s == DIGIT_MASK) begin
                    for (int n = 0; n < 4; n++) begin
                        if (DIGIT_MASK[n]) begin
                            bcd_nxt_s[n] = shadow_nxt_s[n];
                        end else begin
                            bcd_nxt_s[n] = BCD_BLANK;
                        end
                    end
                    fv_nxt_s    = 1'b1;
                    seen_nxt_s  = 4'b0000;
                    state_nxt_s = SYNC;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= SYNC;
            seen_r   <= 4'b0000;
            shadow_r <= {4{BCD_BLANK}};
            bcd_r    <= {4{BCD_BLANK}};
            fv_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            seen_r   <= seen_nxt_s;
            shadow_r <= shadow_nxt_s;
            bcd_r    <= bcd_nxt_s;
            fv_r     <= fv_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count, updated in the same cycle that ERR is raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_nxt_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign ERR_COUNT = err_cnt_r;
`else
    assign ERR_COUNT = 8'd0;
`endif

    assign BCD0        = bcd_r[0];
    assign BCD1        = bcd_r[1];
    assign BCD2        = bcd_r[2];
    assign BCD3        = bcd_r[3];
    assign FRAME_VALID = fv_r;
    assign ERR         = err_r;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: two instances (mask 0011/stable 1 and
// mask 1111/stable 3) checked against a frame-level reference model.
module tb_seven_segment_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] dig_a, dig_b;
    logic [6:0] disp_a, disp_b;
    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic       fv_a, err_a, fv_b, err_b;
    logic [7:0] cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    seven_segment_reader #(.STABLE_CNT(1), .DIGIT_MASK(4'b0011)) dut_a (
        .clk(clk), .rst(rst), .DIGIT(dig_a), .DISPLAY(disp_a),
        .BCD0(a0), .BCD1(a1), .BCD2(a2), .BCD3(a3),
        .FRAME_VALID(fv_a), .ERR(err_a), .ERR_COUNT(cnt_a)
    );

    seven_segment_reader #(.STABLE_CNT(3), .DIGIT_MASK(4'b1111)) dut_b (
        .clk(clk), .rst(rst), .DIGIT(dig_b), .DISPLAY(disp_b),
        .BCD0(b0), .BCD1(b1), .BCD2(b2), .BCD3(b3),
        .FRAME_VALID(fv_b), .ERR(err_b), .ERR_COUNT(cnt_b)
    );

    localparam logic [3:0] IDLE_D = 4'b1111;
    localparam logic [6:0] IDLE_S = 7'b1111111;
    localparam logic [25:0] RST_VEC = {16'hFFFF, 1'b0, 1'b0, 8'd0};

    // digit value i -> pattern; entry 10 is blank
    logic [6:0] seg_tab [11] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b1111111};

    // reference model state, per instance
    logic [10:0] m_prev [2];
    int          m_run  [2];
    logic [3:0]  m_have [2];
    logic [3:0]  m_vals [2][4];
    logic [3:0]  m_bcd  [2][4];
    logic        m_fv   [2];
    logic        m_err  [2];
    int          m_cnt  [2];
    logic [25:0] exp_now [2];

    function automatic int stab_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [3:0] mask_of(int d);
        return (d == 0) ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic [25:0] pend_vec(int d);
        return {m_bcd[d][3], m_bcd[d][2], m_bcd[d][1], m_bcd[d][0], m_fv[d], m_err[d], 8'(m_cnt[d])};
    endfunction

    function automatic logic [25:0] obs_vec(int d);
        if (d == 0) return {a3, a2, a1, a0, fv_a, err_a, cnt_a};
        return {b3, b2, b1, b0, fv_b, err_b, cnt_b};
    endfunction

    task automatic model_reset(int d);
        m_prev[d] = {IDLE_D, IDLE_S};
        m_run[d]  = 0;
        m_have[d] = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            m_vals[d][n] = 4'hF;
            m_bcd[d][n]  = 4'hF;
        end
        m_fv[d]  = 1'b0;
        m_err[d] = 1'b0;
        m_cnt[d] = 0;
    endtask

    task automatic model_error(int d);
        m_err[d]  = 1'b1;
        m_have[d] = 4'b0000;
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
        if (m_cnt[d] < 255) m_cnt[d]++;
`endif
    endtask

    task automatic model_step(int d, logic [3:0] dg, logic [6:0] ds);
        logic [3:0] mk;
        int nlow, idx, val, first;
        mk = mask_of(d);
        if ({dg, ds} == m_prev[d]) begin
            if (m_run[d] < 31) m_run[d]++;
        end else begin
            m_run[d] = 1;
        end
        m_prev[d] = {dg, ds};
        m_fv[d]  = 1'b0;
        m_err[d] = 1'b0;
        if (m_run[d] != stab_of(d)) return;
        nlow = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!dg[i]) begin nlow++; idx = i; end
        if (nlow == 0) return;
        if (nlow > 1) begin model_error(d); return; end
        if (!mk[idx]) return;
        val = -1;
        for (int j = 0; j < 11; j++) if (ds == seg_tab[j]) val = (j == 10) ? 15 : j;
        if (val < 0) begin model_error(d); return; end
        first = 0;
        for (int n = 3; n >= 0; n--) if (mk[n]) first = n;
        if (m_have[d][idx]) m_have[d] = 4'b0000;
        if (m_have[d] == 4'b0000 && idx != first) return;
        m_vals[d][idx] = 4'(val);
        m_have[d][idx] = 1'b1;
        if (m_have[d] == mk) begin
            for (int n = 0; n < 4; n++) if (mk[n]) m_bcd[d][n] = m_vals[d][n];
            m_fv[d]   = 1'b1;
            m_have[d] = 4'b0000;
        end
    endtask

    // drive one cycle on both instances and advance the model
    task automatic tick(input logic [3:0] da, input logic [6:0] sa,
                        input logic [3:0] db, input logic [6:0] sb);
        dig_a = da; disp_a = sa; dig_b = db; disp_b = sb;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                model_reset(d);
                exp_now[d] = pend_vec(d);
            end else begin
                exp_now[d] = pend_vec(d);
                if (d == 0) model_step(0, da, sa);
                else        model_step(1, db, sb);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
        tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_vec(d) !== RST_VEC) begin
                bad++;
                $display("FAIL reset_state inst%0d: got %h want %h", d, obs_vec(d), RST_VEC);
            end
        end
        rst = 1'b0;
        tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
    endtask

    task automatic test_two_digit();
        int fvs = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 10)         tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
            else if (i % 2 == 0) tick(4'b1110, 7'b0000110, IDLE_D, IDLE_S);
            else                 tick(4'b1101, 7'b1001111, IDLE_D, IDLE_S);
            total++;
            if (obs_vec(0) !== exp_now[0]) begin
                bad++;
                $display("FAIL two_digit_model tick %0d: got %h want %h", i, obs_vec(0), exp_now[0]);
            end
            total++;
            if (fv_a !== (i >= 2 && i % 2 == 0)) begin
                bad++;
                $display("FAIL two_digit_cadence tick %0d: got %b want %b", i, fv_a, (i >= 2 && i % 2 == 0));
            end
            if (fv_a === 1'b1) fvs++;
        end
        total++;
        if (fvs != 5) begin bad++; $display("FAIL two_digit_frames: got %0d want 5", fvs); end
        total++;
        if ({a3, a2, a1, a0} !== 16'hFF13) begin
            bad++;
            $display("FAIL two_digit_bcd: got %h want ff13", {a3, a2, a1, a0});
        end
    endtask

    task automatic test_bad_pattern();
        logic [3:0] dq [7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1110, 4'b1101, IDLE_D, IDLE_D};
        logic [6:0] sq [7] = '{7'b0000110, 7'b1010101, 7'b1001111, 7'b0100100, 7'b0001111, IDLE_S, IDLE_S};
        for (int i = 0; i < 7; i++) begin
            tick(dq[i], sq[i], IDLE_D, IDLE_S);
            total++;
            if (obs_vec(0) !== exp_now[0]) begin
                bad++;
                $display("FAIL bad_pattern_model tick %0d: got %h want %h", i, obs_vec(0), exp_now[0]);
            end
            total++;
            if (err_a !== (i == 2) || fv_a !== (i == 5)) begin
                bad++;
                $display("FAIL bad_pattern_pulses tick %0d: got err=%b fv=%b want err=%b fv=%b",
                         i, err_a, fv_a, (i == 2), (i == 5));
            end
            if (i == 2) begin
                total++;
                if ({a3, a2, a1, a0} !== 16'hFF13) begin
                    bad++;
                    $display("FAIL bad_pattern_hold: got %h want ff13", {a3, a2, a1, a0});
                end
            end
        end
        total++;
        if ({a3, a2, a1, a0} !== 16'hFF75) begin
            bad++;
            $display("FAIL bad_pattern_refresh: got %h want ff75", {a3, a2, a1, a0});
        end
    endtask

    task automatic test_stable();
        logic [10:0] seq [$];
        int fvs = 0;
        for (int k = 0; k < 2; k++) seq.push_back({4'b1110, 7'b0000000});
        for (int k = 0; k < 3; k++) seq.push_back({4'b1110, 7'b0000100});
        for (int k = 0; k < 3; k++) seq.push_back({4'b1101, 7'b1001111});
        for (int k = 0; k < 3; k++) seq.push_back({4'b1011, 7'b0010010});
        for (int k = 0; k < 3; k++) seq.push_back({4'b0111, 7'b1001100});
        for (int k = 0; k < 3; k++) seq.push_back({IDLE_D, IDLE_S});
        foreach (seq[i]) begin
            tick(IDLE_D, IDLE_S, seq[i][10:7], seq[i][6:0]);
            total++;
            if (obs_vec(1) !== exp_now[1]) begin
                bad++;
                $display("FAIL stable_model tick %0d: got %h want %h", i, obs_vec(1), exp_now[1]);
            end
            if (fv_b === 1'b1) begin
                fvs++;
                total++;
                if ({b3, b2, b1, b0} !== 16'h4219) begin
                    bad++;
                    $display("FAIL stable_frame: got %h want 4219", {b3, b2, b1, b0});
                end
            end
        end
        total++;
        if (fvs != 1) begin bad++; $display("FAIL stable_frames: got %0d want 1", fvs); end
    endtask

    task automatic test_select();
        logic [3:0] dq [9] = '{4'b1100, IDLE_D, IDLE_D, IDLE_D, 4'b1100, 4'b1100, 4'b1100, IDLE_D, IDLE_D};
        for (int i = 0; i < 9; i++) begin
            tick(dq[i], 7'b0000001, IDLE_D, IDLE_S);
            total++;
            if (obs_vec(0) !== exp_now[0]) begin
                bad++;
                $display("FAIL select_model tick %0d: got %h want %h", i, obs_vec(0), exp_now[0]);
            end
            total++;
            if (err_a !== (i == 1 || i == 5) || fv_a !== 1'b0 || {a3, a2, a1, a0} !== 16'hFF75) begin
                bad++;
                $display("FAIL select_direct tick %0d: got err=%b fv=%b bcd=%h want err=%b fv=0 bcd=ff75",
                         i, err_a, fv_a, {a3, a2, a1, a0}, (i == 1 || i == 5));
            end
        end
    endtask

    task automatic test_reset_midframe();
        tick(4'b1110, 7'b0010010, IDLE_D, IDLE_S);
        rst = 1'b1;
        tick(4'b1101, 7'b0100000, IDLE_D, IDLE_S);
        rst = 1'b0;
        total++;
        if (obs_vec(0) !== RST_VEC) begin
            bad++;
            $display("FAIL midframe_reset: got %h want %h", obs_vec(0), RST_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) tick(4'b1101, 7'b0100000, IDLE_D, IDLE_S);
            else        tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
            total++;
            if (obs_vec(0) !== RST_VEC || obs_vec(0) !== exp_now[0]) begin
                bad++;
                $display("FAIL midframe_after tick %0d: got %h want %h", i, obs_vec(0), RST_VEC);
            end
        end
    endtask

    task automatic test_err_count();
        int errs = 0;
        logic [7:0] want;
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
        want = 8'd255;
`else
        want = 8'd0;
`endif
        for (int i = 0; i < 302; i++) begin
            if (i >= 300)       tick(IDLE_D, IDLE_S, IDLE_D, IDLE_S);
            else if (i % 2 == 0) tick(4'b1010, IDLE_S, IDLE_D, IDLE_S);
            else                tick(4'b1100, IDLE_S, IDLE_D, IDLE_S);
            total++;
            if (obs_vec(0) !== exp_now[0]) begin
                bad++;
                $display("FAIL err_count_model tick %0d: got %h want %h", i, obs_vec(0), exp_now[0]);
            end
            if (err_a === 1'b1) errs++;
        end
        total++;
        if (errs != 300) begin bad++; $display("FAIL err_pulses: got %0d want 300", errs); end
        total++;
        if (cnt_a !== want) begin bad++; $display("FAIL err_count_sat: got %0d want %0d", cnt_a, want); end
    endtask

    task automatic test_random();
        int hold [2] = '{0, 0};
        logic [3:0] cd [2];
        logic [6:0] cs [2];
        int r;
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                if (hold[d] == 0) begin
                    hold[d] = $urandom_range(1, 5);
                    r = $urandom_range(0, 99);
                    if (r < 70)      cd[d] = ~(4'b0001 << $urandom_range(0, 3));
                    else if (r < 85) cd[d] = IDLE_D;
                    else             cd[d] = 4'($urandom);
                    r = $urandom_range(0, 99);
                    if (r < 80) cs[d] = seg_tab[$urandom_range(0, 10)];
                    else        cs[d] = 7'($urandom);
                end
                hold[d]--;
            end
            rst = ($urandom_range(0, 499) == 0);
            tick(cd[0], cs[0], cd[1], cs[1]);
            rst = 1'b0;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_now[d]) begin
                    bad++;
                    $display("FAIL random inst%0d tick %0d: got %h want %h", d, i, obs_vec(d), exp_now[d]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        dig_a = IDLE_D; disp_a = IDLE_S; dig_b = IDLE_D; disp_b = IDLE_S;
        model_reset(0);
        model_reset(1);
        test_reset();
        test_two_digit();
        test_bad_pattern();
        test_stable();
        test_select();
        test_reset_midframe();
        test_err_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
